// File: rtl/dmem_mmio.sv
// Data memory plus MMIO (machine timer, tohost); RAM is not reset.
// Loads answer combinationally in the same cycle; stores commit at the next edge.
// No backpressure: never stalls the core, one access per cycle.
module dmem_mmio #(
    parameter int              XLEN       = 32,
    parameter int              RAM_WORDS  = 4096,
    parameter logic [XLEN-1:0] RAM_BASE   = 32'h8000_0000,
    parameter logic [XLEN-1:0] TIMER_BASE = 32'h0200_0000,
    parameter logic [XLEN-1:0] TOHOST_ADR = 32'h1000_0000
`ifdef DMEM_INIT_FILE_EN
    ,
    parameter string           INIT_FILE  = "dmem.hex"
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    output logic [XLEN-1:0] load_data_o,
    output logic            misaligned_o,
    output logic            timer_irq_o,
    output logic            tohost_v_o,
    output logic [XLEN-1:0] tohost_data_o
);

    localparam int              NB        = XLEN / 8;
    localparam int              AW        = $clog2(RAM_WORDS);
    localparam logic [XLEN-1:0] RAM_BYTES = (XLEN)'(4 * RAM_WORDS);

    logic [XLEN-1:0]   ram_q [RAM_WORDS];
    logic [2*XLEN-1:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic              irq_q, irq_d;
    logic              th_v_q, th_v_d;
    logic [XLEN-1:0]   th_dat_q, th_dat_d;

    logic            sz_b, sz_h, sz_w, bad, st, ld;
    logic            ram_hit, tmr_hit, th_hit, ram_we;
    logic [XLEN-1:0] ram_off, wdat, rd_word, shifted;
    logic [NB-1:0]   be;
    logic [AW-1:0]   ram_idx;

    function automatic logic [XLEN-1:0] merge_be(input logic [XLEN-1:0] old_v,
                                                 input logic [XLEN-1:0] new_v,
                                                 input logic [NB-1:0]   en);
        merge_be = old_v;
        for (int b = 0; b < NB; b++) begin
            if (en[b]) merge_be[8*b +: 8] = new_v[8*b +: 8];
        end
    endfunction

    always_comb begin
        sz_b    = (access_size_i == 3'b001);
        sz_h    = (access_size_i == 3'b010);
        sz_w    = (access_size_i == 3'b100);
        bad     = !(sz_b || sz_h || sz_w) || (sz_h && adr_i[0]) || (sz_w && (adr_i[1:0] != 2'b00));
        st      = adr_v_i && !bad && is_store_i;
        ld      = adr_v_i && !bad && !is_store_i;
        ram_off = adr_i - RAM_BASE;
        ram_idx = adr_i[AW+1:2];
        ram_hit = (ram_off < RAM_BYTES);
        tmr_hit = !ram_hit && (adr_i[XLEN-1:4] == TIMER_BASE[XLEN-1:4]);
        th_hit  = !ram_hit && !tmr_hit && (adr_i == TOHOST_ADR);
        ram_we  = st && ram_hit;

        be   = '1;
        wdat = store_data_i;
        if (sz_b) begin
            be   = (NB)'(1) << adr_i[1:0];
            wdat = {NB{store_data_i[7:0]}};
        end else if (sz_h) begin
            be   = (NB)'(3) << {adr_i[1], 1'b0};
            wdat = {(NB/2){store_data_i[15:0]}};
        end
    end

    // Read path: select source word, shift the addressed lane down, mask to size.
    always_comb begin
        rd_word = '0;
        if (ram_hit) begin
            rd_word = ram_q[ram_idx];
        end else if (tmr_hit) begin
            case (adr_i[3:2])
                2'd0:    rd_word = mtime_q[XLEN-1:0];
                2'd1:    rd_word = mtime_q[2*XLEN-1:XLEN];
                2'd2:    rd_word = mtimecmp_q[XLEN-1:0];
                default: rd_word = mtimecmp_q[2*XLEN-1:XLEN];
            endcase
        end else if (th_hit) begin
            rd_word = th_dat_q;
        end
        shifted = rd_word >> {adr_i[1:0], 3'b000};

        load_data_o = '0;
        if (ld) begin
            if (sz_b)      load_data_o = (XLEN)'(shifted[7:0]);
            else if (sz_h) load_data_o = (XLEN)'(shifted[15:0]);
            else           load_data_o = shifted;
        end
        misaligned_o = adr_v_i && bad;
    end

    // A store to one mtime half overrides the increment; the other half still counts but without carry.
    always_comb begin
        mtime_d    = mtime_q + 1'b1;
        mtimecmp_d = mtimecmp_q;
        if (st && tmr_hit) begin
            case (adr_i[3:2])
                2'd0: mtime_d = {mtime_q[2*XLEN-1:XLEN], merge_be(mtime_q[XLEN-1:0], wdat, be)};
                2'd1: mtime_d = {merge_be(mtime_q[2*XLEN-1:XLEN], wdat, be), mtime_q[XLEN-1:0] + 1'b1};
                2'd2: mtimecmp_d[XLEN-1:0] = merge_be(mtimecmp_q[XLEN-1:0], wdat, be);
                default: mtimecmp_d[2*XLEN-1:XLEN] = merge_be(mtimecmp_q[2*XLEN-1:XLEN], wdat, be);
            endcase
        end
        irq_d = (mtime_d >= mtimecmp_d);

        th_v_d   = th_v_q;
        th_dat_d = th_dat_q;
        if (st && th_hit && sz_w && !th_v_q) begin
            th_v_d   = 1'b1;
            th_dat_d = store_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
            th_v_q     <= 1'b0;
            th_dat_q   <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
            th_v_q     <= th_v_d;
            th_dat_q   <= th_dat_d;
        end
    end

    // RAM keeps its contents through reset; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && ram_we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) ram_q[ram_idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    assign timer_irq_o   = irq_q;
    assign tohost_v_o    = th_v_q;
    assign tohost_data_o = th_dat_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: load expectations go through a scoreboard queue, timer tracked by a small model.
module tb_dmem_mmio;

    localparam logic [2:0] SZ_B = 3'b001, SZ_H = 3'b010, SZ_W = 3'b100;
    localparam logic [31:0] MT_LO = 32'h0200_0000, MT_HI = 32'h0200_0004;
    localparam logic [31:0] CMP_LO = 32'h0200_0008, CMP_HI = 32'h0200_000C;
    localparam logic [31:0] TOHOST = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        adr_v_i = 1'b0;
    logic [31:0] adr_i = '0;
    logic        is_store_i = 1'b0;
    logic [31:0] store_data_i = '0;
    logic [2:0]  access_size_i = SZ_W;
    logic [31:0] load_data_o;
    logic        misaligned_o;
    logic        timer_irq_o;
    logic        tohost_v_o;
    logic [31:0] tohost_data_o;

    int errors = 0;
    int checks = 0;
    logic [63:0] mt;
    logic [63:0] cmp;
    logic [32:0] exp_q[$];
    string       tag_q[$];

    dmem_mmio dut (
        .clk(clk), .reset_n(reset_n), .adr_v_i(adr_v_i), .adr_i(adr_i),
        .is_store_i(is_store_i), .store_data_i(store_data_i), .access_size_i(access_size_i),
        .load_data_o(load_data_o), .misaligned_o(misaligned_o), .timer_irq_o(timer_irq_o),
        .tohost_v_o(tohost_v_o), .tohost_data_o(tohost_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        adr_v_i = 1'b0; is_store_i = 1'b0; store_data_i = '0; access_size_i = SZ_W;
    endtask

    // Ends one cycle at posedge+1, advancing the timer model unless a timer store overrode it.
    task automatic end_cycle(input logic st, input logic [31:0] a, input logic [31:0] d, input logic mis);
        logic [63:0] prev;
        @(posedge clk);
        #1;
        prev = mt;
        mt   = mt + 64'd1;
        if (st && !mis) begin
            if (a == MT_LO)  mt = {prev[63:32], d};
            if (a == MT_HI)  mt = {d, prev[31:0] + 32'd1};
            if (a == CMP_LO) cmp[31:0] = d;
            if (a == CMP_HI) cmp[63:32] = d;
        end
        idle();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz, input logic mis);
        adr_v_i = 1'b1; is_store_i = 1'b1; adr_i = a; store_data_i = d; access_size_i = sz;
        @(negedge clk);
        chk("st_misaligned", {63'd0, misaligned_o}, {63'd0, mis});
        chk("st_irq", {63'd0, timer_irq_o}, {63'd0, (mt >= cmp)});
        end_cycle(1'b1, a, d, mis);
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] exp, input logic mis);
        logic [32:0] e;
        string t;
        adr_v_i = 1'b1; is_store_i = 1'b0; adr_i = a; access_size_i = sz;
        exp_q.push_back({mis, exp});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, {32'd0, load_data_o}, {32'd0, e[31:0]});
        chk({t, "_mis"}, {63'd0, misaligned_o}, {63'd0, e[32]});
        chk({t, "_irq"}, {63'd0, timer_irq_o}, {63'd0, (mt >= cmp)});
        end_cycle(1'b0, a, 32'd0, mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mt  = '0;
        cmp = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq", {63'd0, timer_irq_o}, 64'd0);
        chk("rst_th_v", {63'd0, tohost_v_o}, 64'd0);
        chk("rst_th_dat", {32'd0, tohost_data_o}, 64'd0);
        adr_v_i = 1'b1; adr_i = MT_LO; #1;
        chk("rst_mtime_lo", {32'd0, load_data_o}, 64'd0);
        adr_i = CMP_HI; #1;
        chk("rst_cmp_hi", {32'd0, load_data_o}, 64'h0000_0000_FFFF_FFFF);
        adr_v_i = 1'b0; adr_i = 32'h8000_0003; access_size_i = 3'b111; #1;
        chk("idle_load", {32'd0, load_data_o}, 64'd0);
        chk("idle_mis", {63'd0, misaligned_o}, 64'd0);
        idle();
        reset_n = 1'b1;
        mt = '0;

        // RAM word/half/byte
        store(32'h8000_0010, 32'hDEAD_BEEF, SZ_W, 1'b0);
        load("ld_w", 32'h8000_0010, SZ_W, 32'hDEAD_BEEF, 1'b0);
        load("ld_h", 32'h8000_0012, SZ_H, 32'h0000_DEAD, 1'b0);
        load("ld_b", 32'h8000_0013, SZ_B, 32'h0000_00DE, 1'b0);
        store(32'h8000_0020, 32'h0, SZ_W, 1'b0);
        store(32'h8000_0021, 32'h0000_00AA, SZ_B, 1'b0);
        load("ld_after_b", 32'h8000_0020, SZ_W, 32'h0000_AA00, 1'b0);
        store(32'h8000_0022, 32'h0000_1234, SZ_H, 1'b0);
        load("ld_after_h", 32'h8000_0020, SZ_W, 32'h1234_AA00, 1'b0);

        // Misalignment, illegal size, unmapped
        store(32'h8000_0000, 32'h1122_3344, SZ_W, 1'b0);
        store(32'h8000_0001, 32'h0000_5555, SZ_H, 1'b1);
        load("ram_unchanged", 32'h8000_0000, SZ_W, 32'h1122_3344, 1'b0);
        load("ld_misal", 32'h8000_0002, SZ_W, 32'h0, 1'b1);
        load("ld_badsize", 32'h8000_0000, 3'b011, 32'h0, 1'b1);
        load("ld_unmapped", 32'h4000_0000, SZ_W, 32'h0, 1'b0);
        load("ld_ram_top", 32'h8000_3FFC, SZ_W, 32'hx, 1'b0);

        // tohost
        store(TOHOST, 32'h0000_007F, SZ_B, 1'b0);
        chk("th_byte_dropped", {63'd0, tohost_v_o}, 64'd0);
        store(TOHOST, 32'h1, SZ_W, 1'b0);
        chk("th_v", {63'd0, tohost_v_o}, 64'd1);
        chk("th_dat", {32'd0, tohost_data_o}, 64'd1);
        store(TOHOST, 32'h3, SZ_W, 1'b0);
        chk("th_sticky", {32'd0, tohost_data_o}, 64'd1);
        load("ld_tohost", TOHOST, SZ_W, 32'h1, 1'b0);

        // Async reset pulse mid-cycle
        adr_v_i = 1'b1; is_store_i = 1'b0; adr_i = MT_LO; access_size_i = SZ_W;
        #1 reset_n = 1'b0;
        #1;
        chk("ar_th_v", {63'd0, tohost_v_o}, 64'd0);
        chk("ar_th_dat", {32'd0, tohost_data_o}, 64'd0);
        chk("ar_mtime", {32'd0, load_data_o}, 64'd0);
        chk("ar_irq", {63'd0, timer_irq_o}, 64'd0);
        #1 reset_n = 1'b1;
        mt  = '0;
        cmp = '1;
        end_cycle(1'b0, MT_LO, 32'd0, 1'b0);
        load("ram_survives_rst", 32'h8000_0010, SZ_W, 32'hDEAD_BEEF, 1'b0);

        // Timer interrupt
        store(CMP_HI, 32'h0, SZ_W, 1'b0);
        store(CMP_LO, 32'd20, SZ_W, 1'b0);
        for (int i = 0; i < 24; i++) load("mtime_run", MT_LO, SZ_W, mt[31:0], 1'b0);
        chk("irq_high", {63'd0, timer_irq_o}, 64'd1);
        store(CMP_LO, 32'hFFFF_FFFF, SZ_W, 1'b0);
        chk("irq_drop", {63'd0, timer_irq_o}, 64'd0);

        // mtime write and wrap
        store(MT_LO, 32'hFFFF_FFFE, SZ_W, 1'b0);
        load("wrap_lo0", MT_LO, SZ_W, 32'hFFFF_FFFE, 1'b0);
        load("wrap_lo1", MT_LO, SZ_W, 32'hFFFF_FFFF, 1'b0);
        load("wrap_lo2", MT_LO, SZ_W, 32'h0, 1'b0);
        load("wrap_hi", MT_HI, SZ_W, 32'h1, 1'b0);
        store(MT_LO, 32'hFFFF_FFFE, SZ_W, 1'b0);
        store(MT_HI, 32'hFFFF_FFFF, SZ_W, 1'b0);
        load("full_hi", MT_HI, SZ_W, 32'hFFFF_FFFF, 1'b0);
        load("full_lo", MT_LO, SZ_W, 32'h0, 1'b0);
        load("full_hi0", MT_HI, SZ_W, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
